// File: rtl/rot_bus_regs_if.sv
// rot_bus_regs_if: CPU single-cycle register bus between the CPU port and the RoT register block.
interface rot_bus_regs_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_i;
    logic [WIDTH-1:0] address;
    logic [WIDTH-1:0] data_o;
    logic             re;
    logic             we;
    modport master (output data_i, address, re, we, input data_o);
    modport slave  (input data_i, address, re, we, output data_o);
endinterface

// File: rtl/rot_bus_regs.sv
// rot_bus_regs: Root-of-Trust register window; holds key/plaintext/result registers,
// launches the FSM/PUF/AES/TRNG engines and reports their busy/done status.
module rot_bus_regs #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] BASE  = 32'h1000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    rot_bus_regs_if.slave         bus,
    output logic                  fsm_start,
    output logic                  puf_start,
    output logic                  aes_start,
    output logic                  trng_start,
    output logic [WIDTH-1:0]      fsm_bits,
    output logic [4*WIDTH-1:0]    aes_key,
    output logic [4*WIDTH-1:0]    aes_plain,
    output logic [32*WIDTH-1:0]   puf_plain,
    input  logic                  fsm_done,
    input  logic                  puf_done,
    input  logic                  aes_done,
    input  logic                  trng_done,
    input  logic [4*WIDTH-1:0]    aes_cypher_i,
    input  logic [4*WIDTH-1:0]    trng_i,
    input  logic                  puf_we,
    input  logic [4:0]            puf_waddr,
    input  logic [WIDTH-1:0]      puf_wdata
);
    localparam logic [WIDTH-1:0] OP_CLR     = 0;
    localparam logic [WIDTH-1:0] OP_FSM     = 1;
    localparam logic [WIDTH-1:0] OP_PUF_GEN = 2;
    localparam logic [WIDTH-1:0] OP_AES_RUN = 3;
    localparam logic [WIDTH-1:0] OP_TRNG    = 4;

    logic [3:0][WIDTH-1:0]  r_key, r_plain, r_cyph, r_trng;
    logic [31:0][WIDTH-1:0] r_ppl, r_pcy;
    logic [WIDTH-1:0]       r_fsm_bits;
    logic [3:0]             r_busy;
    logic [3:0]             r_mask;
    logic                   r_cfg, r_pv, r_bad, r_viol;

    logic [WIDTH-1:0] w_off, w_status, w_rdata, w_d;
    logic [6:0]       w_o;
    logic [1:0]       w_i4;
    logic [4:0]       w_i32;
    logic             w_hit, w_st, w_key, w_pln, w_cyp, w_ppl, w_pcy, w_trn, w_fbt, w_op, w_blocked;

    // Every 4-word block starts at offset 1 mod 4 and both 32-word blocks at 13 mod 32.
    assign w_off = bus.address - BASE;
    assign w_hit = w_off < WIDTH'(128);
    assign w_o   = w_off[6:0];
    assign w_i4  = w_o[1:0] - 2'd1;
    assign w_i32 = w_o[4:0] - 5'd13;
    assign w_d   = bus.data_i;

    assign w_st  = w_hit && w_o == 7'd0;
    assign w_key = w_hit && w_o >= 7'd1  && w_o <= 7'd4;
    assign w_pln = w_hit && w_o >= 7'd5  && w_o <= 7'd8;
    assign w_cyp = w_hit && w_o >= 7'd9  && w_o <= 7'd12;
    assign w_ppl = w_hit && w_o >= 7'd13 && w_o <= 7'd44;
    assign w_pcy = w_hit && w_o >= 7'd45 && w_o <= 7'd76;
    assign w_trn = w_hit && w_o >= 7'd77 && w_o <= 7'd80;
    assign w_fbt = w_hit && w_o == 7'd81;
    assign w_op  = w_hit && w_o == 7'd127;

    // r_busy: [0] fsm, [1] trng, [2] puf, [3] aes
    assign w_status  = {r_cfg, r_pv, r_bad, r_viol, 22'd0, &r_mask, r_busy, |r_busy};
    assign w_blocked = ((w_key || w_pln) && r_busy[3]) || (w_ppl && r_busy[2]) || (w_fbt && r_busy[0]);

    always_comb begin
        w_rdata = w_st  ? w_status       :
                  w_pln ? r_plain[w_i4]  :
                  w_cyp ? r_cyph[w_i4]   :
                  w_ppl ? r_ppl[w_i32]   :
                  w_pcy ? r_pcy[w_i32]   :
                  w_trn ? r_trng[w_i4]   :
                  w_fbt ? r_fsm_bits     : '0;
    end

    assign fsm_bits  = r_fsm_bits;
    assign aes_key   = r_key;
    assign aes_plain = r_plain;
    assign puf_plain = r_ppl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data_o <= '0;
            r_key      <= '0;
            r_plain    <= '0;
            r_cyph     <= '0;
            r_trng     <= '0;
            r_ppl      <= '0;
            r_pcy      <= '0;
            r_fsm_bits <= '0;
            r_busy     <= '0;
            r_mask     <= '0;
            {r_cfg, r_pv, r_bad, r_viol} <= '0;
            {fsm_start, puf_start, aes_start, trng_start} <= '0;
        end else begin
            {fsm_start, puf_start, aes_start, trng_start} <= '0;
            if (bus.re) bus.data_o <= w_rdata;
            if (puf_we) r_pcy[puf_waddr] <= puf_wdata;
            if (fsm_done && r_busy[0]) begin
                r_busy[0] <= 1'b0;
                r_cfg     <= 1'b1;
            end
            if (trng_done && r_busy[1]) begin
                r_busy[1] <= 1'b0;
                r_trng    <= trng_i;
            end
            if (puf_done && r_busy[2]) begin
                r_busy[2] <= 1'b0;
                r_pv      <= 1'b1;
            end
            if (aes_done && r_busy[3]) begin
                r_busy[3] <= 1'b0;
                r_cyph    <= aes_cypher_i;
            end
            // Launches only happen with all engines idle, so they never collide with a done clear.
            if (bus.we) begin
                if (w_blocked) r_viol <= 1'b1;
                else if (w_key) begin
                    r_key[w_i4]  <= w_d;
                    r_mask[w_i4] <= 1'b1;
                end
                else if (w_pln) r_plain[w_i4] <= w_d;
                else if (w_ppl) r_ppl[w_i32] <= w_d;
                else if (w_fbt) r_fsm_bits <= w_d;
                else if (w_op) begin
                    if (w_d == OP_CLR) {r_bad, r_viol} <= 2'b00;
                    else if (|r_busy) r_viol <= 1'b1;
                    else if (w_d == OP_FSM) begin
                        fsm_start <= 1'b1;
                        r_busy[0] <= 1'b1;
                    end
                    else if (w_d == OP_TRNG) begin
                        trng_start <= 1'b1;
                        r_busy[1]  <= 1'b1;
                    end
                    else if (w_d == OP_PUF_GEN) begin
                        puf_start <= 1'b1;
                        r_busy[2] <= 1'b1;
                    end
                    else if (w_d == OP_AES_RUN && &r_mask) begin
                        aes_start <= 1'b1;
                        r_busy[3] <= 1'b1;
                    end
                    else r_bad <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/rot_bus_regs.md
# rot_bus_regs

Memory-mapped register responder of the Root-of-Trust: it decodes CPU single-cycle reads and writes in the 128-word window at 32'h1000_0000 and holds the key, plaintext, result and configuration registers. It launches the FSM, PUF, AES and TRNG engines from the opcode register and tracks their busy/done handshakes. It reports global and per-engine status to the polling CPU. It sits between the CPU bus port of the `rot` top level and the crypto engines.

## Interface
- WIDTH, 32, bus data/address width (only 32 supported)
- BASE, 32'h1000_0000, window base address

- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- data_i  in  WIDTH  write data
- address  in  WIDTH  byte-free word address
- re  in  1  read strobe, one cycle per access
- we  in  1  write strobe, one cycle per access
- data_o  out  WIDTH  registered read data
- fsm_start / puf_start / aes_start / trng_start  out  1  one-cycle engine launch pulses
- fsm_bits  out  32  FSM configuration word
- aes_key, aes_plain  out  128  word 0 at bits [31:0]
- puf_plain  out  1024  word 0 at bits [31:0]
- fsm_done / puf_done / aes_done / trng_done  in  1  one-cycle completion pulses
- aes_cypher_i, trng_i  in  128  captured on the matching done pulse
- puf_we  in  1, puf_waddr  in  5, puf_wdata  in  32  PUF result word writes into the PUF_CYPHER buffer

## Operation
- Offsets (address-BASE): 0 STATUS RO; 1-4 AES_KEY WO (read 0); 5-8 AES_PLAIN RW; 9-12 AES_CYPHER RO; 13-44 PUF_PLAIN RW; 45-76 PUF_CYPHER RO; 77-80 TRNG RO; 81 FSM_BITS RW; 127 OP_REG WO (read 0). Unmapped offsets and out-of-window addresses: writes ignored, reads return 0.
- Writes to RO offsets: ignored, no error.
- Opcodes (opcodes.vh): OP_CLR=0, OP_FSM=1, OP_PUF_GEN=2, OP_AES_RUN=3, OP_TRNG=4.
- STATUS: [0] global busy = OR of [1..4]; [1] fsm_busy; [2] trng_busy; [3] puf_busy; [4] aes_busy; [5] aes_key_loaded; [31] fsm_configured; [30] puf_valid; [29] bad_opcode; [28] busy_violation; all others 0.
- OP write, global busy 0: OP_FSM/PUF_GEN/AES_RUN/TRNG pulses the matching start and sets the matching busy. OP_AES_RUN with [5]=0 is not launched; it sets [29] instead. OP_CLR clears [29:28]. Any other value sets [29].
- OP write while global busy 1: ignored, sets [28] (OP_CLR still honoured).
- Writes to AES_KEY, AES_PLAIN, PUF_PLAIN or FSM_BITS while the consuming engine is busy: ignored, set [28].
- Per-engine key-word mask: bit set on each AES_KEY write. [5] set once all 4 bits are set. Never cleared except by reset.
- Done pulses: clear the busy bit. fsm_done sets [31]. puf_done sets [30]. aes_done/trng_done capture result registers. A done with busy 0 is ignored.
- PUF_CYPHER buffer accepts puf_we at any time.
- Sticky bits [31:28] clear only by reset or OP_CLR (which clears [29:28] only).

## Timing
- Reset: data_o=0, every register, buffer, mask and status bit 0, start pulses 0.
- Write takes effect at the rising edge with we=1. A start pulse is asserted the cycle after the OP write edge, for exactly 1 cycle. The busy bit is visible in STATUS from that same cycle.
- Read: data_o updated at the rising edge with re=1. It holds its value until the next read (latency 1).
- re and we in the same cycle: write happens, data_o returns the pre-write value.
- A done pulse in the same cycle as a STATUS read: the read returns busy=1, and the next read returns busy=0.
- A done pulse and a new OP write in the same cycle: the OP is treated as busy (sets [28]).
- puf_we and a read of the same PUF_CYPHER word in the same cycle: the read returns the old word.
- Reset asserted mid-operation clears busy immediately. Engine done pulses arriving after reset are ignored.

## Test plan
- Reset, then read STATUS -> 0, and read FSM_BITS -> 0. Then write FSM_BITS=32'hF0F0_AAAA and read it back -> 32'hF0F0_AAAA.
- Write OP_FSM -> fsm_start pulses once, and STATUS = 32'h0000_0003. Assert fsm_done -> the next STATUS read = 32'h8000_0000.
- Write 32'h1234_5678 to AES_KEY words 0-2 -> [5]=0. Write word 3 -> [5]=1, and aes_key = {4{32'h1234_5678}}. Reading AES_KEY returns 0.
- Write OP_PUF_GEN, then stream 32 puf_we words i -> i, then puf_done. PUF_CYPHER+i reads i, and STATUS = 32'hC000_0020 (with [31] already set).
- Write OP_AES_RUN 8 times, each followed by aes_done with aes_cypher_i=128'hA5... -> 8 aes_start pulses. Final STATUS[5:0] = 6'b100000 and [31:26] = 6'b110000.
- Write OP_TRNG while aes_busy=1 -> no trng_start, [28]=1. Write opcode 7 -> [29]=1. Write OP_CLR -> [29:28]=0.
